// File: rtl/average_filter_ctrl.sv
// average_filter_ctrl: stereo moving-average sequencer (flush, warmup mute, bypass, overrun); optional AVG_CTRL_OVERRUN_CNT_EN adds overrun_count
module average_filter_ctrl #(
  parameter int AUDIO_DATA_WIDTH = 24,
  parameter int NUMBER_OF_SAMPLES = 32,
  parameter int PIPE_DEPTH = 2,
  parameter int FLUSH_LEN = NUMBER_OF_SAMPLES + PIPE_DEPTH + 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        sample_valid,
  input  logic [AUDIO_DATA_WIDTH-1:0] left_in,
  input  logic [AUDIO_DATA_WIDTH-1:0] right_in,
  input  logic                        bypass,
  input  logic                        clear_req,
  output logic                        filt_enable,
  output logic [AUDIO_DATA_WIDTH-1:0] filt_signal_l,
  output logic [AUDIO_DATA_WIDTH-1:0] filt_signal_r,
  input  logic [AUDIO_DATA_WIDTH-1:0] filt_result_l,
  input  logic [AUDIO_DATA_WIDTH-1:0] filt_result_r,
  output logic [AUDIO_DATA_WIDTH-1:0] left_out,
  output logic [AUDIO_DATA_WIDTH-1:0] right_out,
  output logic                        out_valid,
  output logic                        ready,
`ifdef AVG_CTRL_OVERRUN_CNT_EN
  output logic [15:0]                 overrun_count,
`endif
  output logic                        overrun
);
  localparam int WARM_LEN = NUMBER_OF_SAMPLES + PIPE_DEPTH;
  localparam int FW = $clog2(FLUSH_LEN + 1);
  localparam int WW = $clog2(WARM_LEN + 1);
  typedef enum logic [1:0] {CLEAR, WARMUP, RUN} state_t;
  state_t state, state_nxt;
  logic [FW-1:0] flush_cnt;
  logic [WW-1:0] warm_cnt;
  logic accept, drop;
  logic v1, v2, byp1, byp2, mute1, mute2;
  logic [AUDIO_DATA_WIDTH-1:0] raw1_l, raw1_r, raw2_l, raw2_r;
  always_comb begin
    accept = sample_valid && !clear_req && state != CLEAR;
    drop = sample_valid && !clear_req && state == CLEAR;
    state_nxt = state;
    if (clear_req)
      state_nxt = CLEAR;
    else if (state == CLEAR && flush_cnt == FW'(FLUSH_LEN - 1))
      state_nxt = WARMUP;
    else if (state == WARMUP && accept && warm_cnt == WW'(WARM_LEN - 1))
      state_nxt = RUN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      flush_cnt <= '0;
      warm_cnt <= '0;
      ready <= 1'b0;
      filt_enable <= 1'b0;
      filt_signal_l <= '0;
      filt_signal_r <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      byp1 <= 1'b0;
      byp2 <= 1'b0;
      mute1 <= 1'b0;
      mute2 <= 1'b0;
      raw1_l <= '0;
      raw1_r <= '0;
      raw2_l <= '0;
      raw2_r <= '0;
      out_valid <= 1'b0;
      left_out <= '0;
      right_out <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      ready <= state_nxt != CLEAR;
      flush_cnt <= (clear_req || state != CLEAR) ? '0 : flush_cnt + 1'b1;
      warm_cnt <= clear_req ? '0 : (accept && warm_cnt != WW'(WARM_LEN)) ? warm_cnt + 1'b1 : warm_cnt;
      // flush enables carry zero samples; accepted samples go straight to the cores
      filt_enable <= !clear_req && (state == CLEAR || accept);
      filt_signal_l <= accept ? left_in : '0;
      filt_signal_r <= accept ? right_in : '0;
      v1 <= accept;
      byp1 <= bypass;
      mute1 <= state == WARMUP;
      raw1_l <= left_in;
      raw1_r <= right_in;
      v2 <= v1 && !clear_req;
      byp2 <= byp1;
      mute2 <= mute1;
      raw2_l <= raw1_l;
      raw2_r <= raw1_r;
      out_valid <= v2 && !clear_req;
      left_out <= clear_req ? '0 : !v2 ? left_out : mute2 ? '0 : byp2 ? raw2_l : filt_result_l;
      right_out <= clear_req ? '0 : !v2 ? right_out : mute2 ? '0 : byp2 ? raw2_r : filt_result_r;
      overrun <= overrun | drop;
    end
  end
`ifdef AVG_CTRL_OVERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      overrun_count <= '0;
    else if (drop && overrun_count != 16'hFFFF)
      overrun_count <= overrun_count + 16'd1;
  end
`endif
endmodule
